// File: rtl/inst_enc_dec_core.sv
// inst_enc_dec_core: registered SEC-DED Hamming(13,8) loop-back.
// Stage 1 encodes IN into a 13-bit codeword; an XOR error channel (err_mask)
// sits between stage 1 and stage 2; stage 2 corrects single-bit errors and
// flags double-bit errors.
// Optional feature macro: INST_ENC_DEC_ERR_COUNT_EN adds saturating
// sec_count / ded_count outputs.
module inst_enc_dec_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  IN,
    input  logic [12:0] err_mask,
    output logic        C1,
    output logic        c2,
    output logic        c3,
    output logic        c4,
    output logic [7:0]  OUT,
    output logic        single_bit_ERROR,
    output logic        two_bit_ERROR
`ifdef INST_ENC_DEC_ERR_COUNT_EN
    ,
    output logic [7:0]  sec_count,
    output logic [7:0]  ded_count
`endif
);

    // Build the codeword: data at non-power-of-two positions, check bits at
    // 1/2/4/8, overall parity in bit 0.
    function automatic logic [12:0] hamming_encode(input logic [7:0] d);
        logic [12:0] cw;
        cw     = '0;
        cw[3]  = d[0];
        cw[5]  = d[1];
        cw[6]  = d[2];
        cw[7]  = d[3];
        cw[9]  = d[4];
        cw[10] = d[5];
        cw[11] = d[6];
        cw[12] = d[7];
        cw[1]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        cw[2]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        cw[4]  = d[1] ^ d[2] ^ d[3] ^ d[7];
        cw[8]  = d[4] ^ d[5] ^ d[6] ^ d[7];
        cw[0]  = ^cw[12:1];
        return cw;
    endfunction

    // Pull the eight data bits back out of a codeword.
    function automatic logic [7:0] extract_data(input logic [12:0] cw);
        return {cw[12], cw[11], cw[10], cw[9], cw[7], cw[6], cw[5], cw[3]};
    endfunction

    // Syndrome: each bit is the parity over the positions it covers,
    // including its own check position, so a clean word gives zero.
    function automatic logic [3:0] hamming_syndrome(input logic [12:0] cw);
        logic [3:0] s;
        s[0] = cw[1] ^ cw[3] ^ cw[5] ^ cw[7] ^ cw[9]  ^ cw[11];
        s[1] = cw[2] ^ cw[3] ^ cw[6] ^ cw[7] ^ cw[10] ^ cw[11];
        s[2] = cw[4] ^ cw[5] ^ cw[6] ^ cw[7] ^ cw[12];
        s[3] = cw[8] ^ cw[9] ^ cw[10] ^ cw[11] ^ cw[12];
        return s;
    endfunction

    logic [12:0] enc_cw_p1;
    logic [12:0] rx_cw;
    logic [12:0] fix_mask;
    logic [3:0]  syn;
    logic        par;
    logic [7:0]  data_nxt;
    logic        sec_nxt;
    logic        ded_nxt;

    // ---- stage 1: encode register ----
    // Register the codeword of IN; check-bit outputs come straight from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_cw_p1 <= '0;
        end else begin
            enc_cw_p1 <= hamming_encode(IN);
        end
    end

    assign C1 = enc_cw_p1[1];
    assign c2 = enc_cw_p1[2];
    assign c3 = enc_cw_p1[4];
    assign c4 = enc_cw_p1[8];

    // Channel injection plus syndrome/parity classification and correction.
    always_comb begin
        rx_cw    = enc_cw_p1 ^ err_mask;
        syn      = hamming_syndrome(rx_cw);
        par      = ^rx_cw;
        fix_mask = '0;
        sec_nxt  = 1'b0;
        ded_nxt  = 1'b0;
        if (par) begin
            if (syn == 4'd0) begin
                // only the overall parity bit was hit
                sec_nxt = 1'b1;
            end else if (syn <= 4'd12) begin
                sec_nxt  = 1'b1;
                fix_mask = 13'd1 << syn;
            end else begin
                // syndrome points outside the codeword
                ded_nxt = 1'b1;
            end
        end else if (syn != 4'd0) begin
            ded_nxt = 1'b1;
        end
        data_nxt = extract_data(rx_cw ^ fix_mask);
    end

    // ---- stage 2: decode register ----
    // Register corrected data and the mutually exclusive error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OUT              <= '0;
            single_bit_ERROR <= 1'b0;
            two_bit_ERROR    <= 1'b0;
        end else begin
            OUT              <= data_nxt;
            single_bit_ERROR <= sec_nxt;
            two_bit_ERROR    <= ded_nxt;
        end
    end

`ifdef INST_ENC_DEC_ERR_COUNT_EN
    // Saturating counts of cycles on which each registered flag is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_count <= '0;
            ded_count <= '0;
        end else begin
            if (single_bit_ERROR && (sec_count != 8'hFF)) begin
                sec_count <= sec_count + 8'd1;
            end
            if (two_bit_ERROR && (ded_count != 8'hFF)) begin
                ded_count <= ded_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_enc_dec_core.sv
// Scoreboard bench for inst_enc_dec_core: a driver pushes expected responses
// into queues, a monitor pops and compares each cycle the DUT presents them.
// Expected values come from a position-based Hamming model.
module tb_inst_enc_dec_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  IN = 8'h00;
    logic [12:0] err_mask = 13'h0;
    logic        C1, c2, c3, c4;
    logic [7:0]  OUT;
    logic        single_bit_ERROR, two_bit_ERROR;
`ifdef INST_ENC_DEC_ERR_COUNT_EN
    logic [7:0]  sec_count, ded_count;
`endif

    inst_enc_dec_core dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .IN               (IN),
        .err_mask         (err_mask),
        .C1               (C1),
        .c2               (c2),
        .c3               (c3),
        .c4               (c4),
        .OUT              (OUT),
        .single_bit_ERROR (single_bit_ERROR),
        .two_bit_ERROR    (two_bit_ERROR)
`ifdef INST_ENC_DEC_ERR_COUNT_EN
        ,
        .sec_count        (sec_count),
        .ded_count        (ded_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       sec;
        logic       ded;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] chk_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [7:0]  prev_d;
    logic [12:0] prev_m;
    bit          have_prev = 0;

    // Codeword built from Hamming position rules: bit at power-of-two
    // position p is the parity of every data position whose index has p set.
    function automatic logic [12:0] model_encode(input logic [7:0] d);
        int dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        logic [12:0] cw;
        cw = '0;
        for (int i = 0; i < 8; i++) cw[dpos[i]] = d[i];
        for (int b = 0; b < 4; b++) begin
            int p;
            logic x;
            p = 1 << b;
            x = 1'b0;
            for (int k = 1; k <= 12; k++)
                if ((k & p) != 0 && k != p) x ^= cw[k];
            cw[p] = x;
        end
        cw[0] = ^cw[12:1];
        return cw;
    endfunction

    function automatic exp_t model_decode(input logic [7:0] d, input logic [12:0] m);
        int dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        logic [12:0] rx;
        int syn;
        logic p;
        exp_t e;
        rx  = model_encode(d) ^ m;
        syn = 0;
        for (int k = 1; k <= 12; k++) if (rx[k]) syn ^= k;
        p = ^rx;
        e.sec = 1'b0;
        e.ded = 1'b0;
        if (p && syn == 0) e.sec = 1'b1;
        else if (p && syn <= 12) begin
            e.sec = 1'b1;
            rx[syn] = ~rx[syn];
        end else if (syn != 0) e.ded = 1'b1;
        for (int i = 0; i < 8; i++) e.data[i] = rx[dpos[i]];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_chk"}, {28'd0, c4, c3, c2, C1}, 32'd0);
        check({tag, "_dec"}, {22'd0, OUT, single_bit_ERROR, two_bit_ERROR}, 32'd0);
`ifdef INST_ENC_DEC_ERR_COUNT_EN
        check({tag, "_cnt"}, {16'd0, sec_count, ded_count}, 32'd0);
`endif
    endtask

    // One word per cycle: IN carries the new word, err_mask the channel
    // error for the word already held in stage 1.
    task automatic drive(input logic [7:0] d, input logic [12:0] m);
        logic [12:0] cw;
        @(posedge clk);
        #1;
        if (have_prev) begin
            err_mask = prev_m;
            exp_q.push_back(model_decode(prev_d, prev_m));
        end
        IN = d;
        cw = model_encode(d);
        chk_q.push_back({cw[8], cw[4], cw[2], cw[1]});
        prev_d = d;
        prev_m = m;
        have_prev = 1;
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        if (have_prev) begin
            err_mask = prev_m;
            exp_q.push_back(model_decode(prev_d, prev_m));
        end
        have_prev = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [12:0] rand_mask();
        int sel, i, j;
        sel = $urandom_range(0, 3);
        i = $urandom_range(0, 12);
        j = (i + 1 + $urandom_range(0, 11)) % 13;
        case (sel)
            0: return 13'h0;
            1: return 13'd1 << i;
            2: return (13'd1 << i) | (13'd1 << j);
            default: return 13'($urandom);
        endcase
    endfunction

    // Monitor: compare whatever was expected before the latest edge.
    initial begin
        int nc, na;
        exp_t e;
        logic [3:0] c;
        forever begin
            @(posedge clk);
            nc = chk_q.size();
            na = exp_q.size();
            @(negedge clk);
            if (nc > 0 && chk_q.size() > 0) begin
                c = chk_q.pop_front();
                check("check_bits", {28'd0, c4, c3, c2, C1}, {28'd0, c});
            end
            if (na > 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("decode", {22'd0, OUT, single_bit_ERROR, two_bit_ERROR},
                      {22'd0, e.data, e.sec, e.ded});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset with the clock running and nonzero IN
        IN = 8'hFF;
        err_mask = 13'h0;
        #2 rst_n = 1'b0;
        #1 check_zero("reset_async");
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_zero("reset_held");
        end
        rst_n = 1'b1;

        // directed cases
        drive(8'b11100100, 13'h0);
        drive(8'b11100100, 13'd1 << 6);
        drive(8'b11100100, (13'd1 << 3) | (13'd1 << 5));
        drive(8'h00, 13'd1 << 0);
        drive(8'h00, 13'd1 << 8);
        drive(8'h5A, 13'h112);
        drive(8'hA5, 13'h0);
        drive(8'h3C, 13'h0);
        drive(8'hFF, 13'h0);
        drive(8'h81, 13'd1 << 12);
        drive(8'h7E, (13'd1 << 0) | (13'd1 << 12));

        // randomized stream
        for (int n = 0; n < 200; n++) drive(8'($urandom), rand_mask());
        drain();

        // reset asserted mid-stream discards in-flight words
        drive(8'hC3, 13'd1 << 2);
        drive(8'h19, 13'h0);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        chk_q.delete();
        have_prev = 0;
        #1 check_zero("reset_mid");
        @(posedge clk);
        @(negedge clk);
        check_zero("reset_mid_held");
        rst_n = 1'b1;

        for (int n = 0; n < 40; n++) drive(8'($urandom), rand_mask());
        drain();

`ifdef INST_ENC_DEC_ERR_COUNT_EN
        // saturating counters: 300 consecutive single-error words
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_zero("reset_cnt");
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 300; n++) drive(8'($urandom), 13'd1 << $urandom_range(0, 12));
        drain();
        check("sec_count_sat", {24'd0, sec_count}, 32'd255);
        check("ded_count_zero", {24'd0, ded_count}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
